// File: rtl/inverse_permute_map.sv
// -----------------------------------------------------------------------------
// inverse_permute_map
//
// Decrypt-side bit-permutation stage of the encrypter v2 datapath. It applies
// the inverse of the fixed 64-entry forward permutation ROUNDS times to each
// accepted block, which recovers the pre-permutation block. It has
// valid/ready handshakes on both the input side and the output side.
//
// Bit numbering: vectors are [0:63], and bit 0 is the MSB. The inverse map is
// out[j] = in[INV_TAB[j]]. The forward map is its transpose,
// out[INV_TAB[j]] = in[j].
//
// Parameters:
//   ROUNDS     passes per block, 1..255 (must match the encrypt side)
//
// Optional build macro:
//   PERMUTE_DIR_SEL_EN  adds input 'dir'. It is sampled at the accept edge.
//                       dir=1 applies the forward map for every round.
//                       dir=0 applies the inverse map.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   set        synchronous abort/clear: go to IDLE and zero the outputs
//   in_valid   data_in holds a block
//   in_ready   block can be accepted (registered, IDLE only)
//   data_in    permuted block
//   out_valid  data_out holds a finished block
//   out_ready  downstream accepts data_out
//   data_out   recovered block (zero unless in DONE)
//   status     high while in DONE (mirrors out_valid)
// -----------------------------------------------------------------------------
module inverse_permute_map #(
    parameter int ROUNDS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] data_out,
    output logic        status
`ifdef PERMUTE_DIR_SEL_EN
   ,input  logic        dir
`endif
);

    if (ROUNDS < 1 || ROUNDS > 255) begin : g_rounds_chk
        $error("inverse_permute_map: ROUNDS must be within 1..255");
    end

    localparam logic [7:0] RLAST = 8'(ROUNDS);

    localparam int INV_TAB [64] = '{
        26, 51, 41, 11, 34, 56, 12, 50, 61, 25, 55, 44, 35, 49, 21, 58,
        24, 43, 18,  2, 33, 36, 52, 32, 63,  1, 53, 42, 57,  3, 31, 22,
        13, 54,  9, 40,  5, 37, 19, 62, 39,  8, 29,  0, 27, 20, 59, 48,
        16, 28, 45,  7, 17,  4, 30, 23, 47, 14,  6, 38, 10, 15, 46, 60
    };

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state, state_nx;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;
    logic [0:63] work;
    logic        accept;
    logic [0:63] perm_src;
    logic [0:63] perm_inv;
    logic [0:63] perm_out;

    assign accept  = (state == S_IDLE) && in_ready && in_valid;
    assign cnt_inc = cnt + 8'd1;

    // A single permutation network serves both the accept pass (which reads
    // data_in) and the RUN passes (which read the work register).
    assign perm_src = accept ? data_in : work;

    for (genvar j = 0; j < 64; j++) begin : g_inv
        assign perm_inv[j] = perm_src[INV_TAB[j]];
    end

`ifdef PERMUTE_DIR_SEL_EN
    logic        dir_q;
    logic        dir_sel;
    logic [0:63] perm_fwd;

    // At the accept edge, the live dir input selects the map. After that, the
    // stored copy selects it, so every round of a block uses the same map.
    assign dir_sel = accept ? dir : dir_q;

    for (genvar j = 0; j < 64; j++) begin : g_fwd
        assign perm_fwd[INV_TAB[j]] = perm_src[j];
    end

    assign perm_out = dir_sel ? perm_fwd : perm_inv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else if (set) begin
            dir_q <= 1'b0;
        end else if (accept) begin
            dir_q <= dir;
        end
    end
`else
    assign perm_out = perm_inv;
`endif

    // Next-state logic. set has priority over every other transition.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = (ROUNDS == 1) ? S_DONE : S_RUN;
            S_RUN:  if (cnt_inc == RLAST) state_nx = S_DONE;
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (set) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            work     <= '0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nx;
            // in_ready is registered from the next state. It is therefore low
            // in the first cycle after reset release and in the out_ready
            // cycle. This enforces at least one IDLE cycle between blocks.
            in_ready <= (state_nx == S_IDLE);
            if (set) begin
                cnt  <= 8'd0;
                work <= '0;
            end else begin
                case (state)
                    S_IDLE: if (accept) begin
                        work <= perm_out;
                        cnt  <= 8'd1;
                    end
                    S_RUN: begin
                        work <= perm_out;
                        cnt  <= cnt_inc;
                    end
                    S_DONE: if (out_ready) cnt <= 8'd0;
                    default: cnt <= 8'd0;
                endcase
            end
        end
    end

    assign out_valid = (state == S_DONE);
    assign status    = out_valid;
    assign data_out  = out_valid ? work : '0;

endmodule

// File: tb/tb_inverse_permute_map.sv
module tb_inverse_permute_map;

  localparam int NI = 3;   // instances with ROUNDS = 1, 2, 4

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        set_s [NI];
  logic        iv    [NI];
  logic        ir    [NI];
  logic        ov    [NI];
  logic        ordy  [NI];
  logic        st    [NI];
  logic [63:0] din   [NI];
  logic [63:0] dout  [NI];

  int vec = 0;
  int bad = 0;

  int INV [64] = '{
    26, 51, 41, 11, 34, 56, 12, 50, 61, 25, 55, 44, 35, 49, 21, 58,
    24, 43, 18,  2, 33, 36, 52, 32, 63,  1, 53, 42, 57,  3, 31, 22,
    13, 54,  9, 40,  5, 37, 19, 62, 39,  8, 29,  0, 27, 20, 59, 48,
    16, 28, 45,  7, 17,  4, 30, 23, 47, 14,  6, 38, 10, 15, 46, 60
  };
  int FWD [64];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    inverse_permute_map #(.ROUNDS(k == 0 ? 1 : (k == 1 ? 2 : 4))) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .set      (set_s[k]),
      .in_valid (iv[k]),
      .in_ready (ir[k]),
      .data_in  (din[k]),
      .out_valid(ov[k]),
      .out_ready(ordy[k]),
      .data_out (dout[k]),
      .status   (st[k])
`ifdef PERMUTE_DIR_SEL_EN
     ,.dir      (1'b0)
`endif
    );
  end

  // Reference model. The spec numbers bits 0..63 from the MSB, so spec bit b
  // is bit (63-b) of a [63:0] vector.
  function automatic int rounds_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  function automatic logic [63:0] p_inv(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int j = 0; j < 64; j++) y[63-j] = x[63-INV[j]];
    return y;
  endfunction

  function automatic logic [63:0] p_fwd(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[63-FWD[i]];
    return y;
  endfunction

  function automatic logic [63:0] model(input int k, input logic [63:0] x);
    logic [63:0] y = x;
    for (int r = 0; r < rounds_of(k); r++) y = p_inv(y);
    return y;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents d on instance k and returns just after the accepting edge.
  task automatic send(input int k, input logic [63:0] d);
    int n = 0;
    iv[k] = 1'b1; din[k] = d;
    while (!ir[k] && n < 20) begin step(); n++; end
    step();
    iv[k] = 1'b0; din[k] = rnd64();
  endtask

  // Returns the latency in edges, counting the accept edge, or -1 on timeout.
  task automatic wait_valid(input int k, output int lat);
    lat = 1;
    while (!ov[k] && lat < 64) begin step(); lat++; end
    if (!ov[k]) lat = -1;
  endtask

  task automatic drain(input int k);
    ordy[k] = 1'b1; step(); ordy[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < NI; k++) begin
      vec++; if (ov[k] !== 1'b0)    begin bad++; $display("FAIL reset_ov[%0d] got %b want 0", k, ov[k]); end
      vec++; if (ir[k] !== 1'b0)    begin bad++; $display("FAIL reset_ir[%0d] got %b want 0", k, ir[k]); end
      vec++; if (st[k] !== 1'b0)    begin bad++; $display("FAIL reset_st[%0d] got %b want 0", k, st[k]); end
      vec++; if (dout[k] !== 64'd0) begin bad++; $display("FAIL reset_dout[%0d] got %h want 0", k, dout[k]); end
    end
    step(); step();
    rst_n = 1'b1;
    #1;
    vec++; if (ir[0] !== 1'b0) begin bad++; $display("FAIL release_ir got %b want 0", ir[0]); end
    step();
    for (int k = 0; k < NI; k++) begin
      vec++; if (ir[k] !== 1'b1) begin bad++; $display("FAIL ready_after_release[%0d] got %b want 1", k, ir[k]); end
    end
  endtask

  task automatic test_vectors();
    int lat;
    logic [63:0] vin  [3] = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000};
    logic [63:0] vexp [3] = '{64'h0000_0000_0010_0000, 64'h0000_0080_0000_0000, 64'h0000_4000_0000_0000};
    int          vk   [3] = '{0, 0, 1};
    for (int t = 0; t < 3; t++) begin
      send(vk[t], vin[t]);
      wait_valid(vk[t], lat);
      vec++; if (lat !== rounds_of(vk[t])) begin bad++; $display("FAIL vec_latency[%0d] got %0d want %0d", t, lat, rounds_of(vk[t])); end
      vec++; if (dout[vk[t]] !== vexp[t]) begin bad++; $display("FAIL vec_data[%0d] got %h want %h", t, dout[vk[t]], vexp[t]); end
      vec++; if (st[vk[t]] !== 1'b1) begin bad++; $display("FAIL vec_status[%0d] got %b want 1", t, st[vk[t]]); end
      drain(vk[t]);
      vec++; if (ov[vk[t]] !== 1'b0) begin bad++; $display("FAIL vec_ov_drop[%0d] got %b want 0", t, ov[vk[t]]); end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [63:0] x = rnd64();
    send(2, rnd64());
    step();          // second round applied, block still in flight
    #2 rst_n = 1'b0;
    #1;
    vec++; if (ov[2] !== 1'b0)    begin bad++; $display("FAIL midrst_ov got %b want 0", ov[2]); end
    vec++; if (ir[2] !== 1'b0)    begin bad++; $display("FAIL midrst_ir got %b want 0", ir[2]); end
    vec++; if (dout[2] !== 64'd0) begin bad++; $display("FAIL midrst_dout got %h want 0", dout[2]); end
    step();
    rst_n = 1'b1;
    #1;
    vec++; if (ir[2] !== 1'b0) begin bad++; $display("FAIL midrst_release_ir got %b want 0", ir[2]); end
    step();
    vec++; if (ir[2] !== 1'b1) begin bad++; $display("FAIL midrst_ready got %b want 1", ir[2]); end
    vec++; if (ov[2] !== 1'b0) begin bad++; $display("FAIL midrst_no_stale got %b want 0", ov[2]); end
    send(2, x);
    wait_valid(2, lat);
    vec++; if (dout[2] !== model(2, x)) begin bad++; $display("FAIL midrst_next got %h want %h", dout[2], model(2, x)); end
    drain(2);
  endtask

  task automatic test_round_trip();
    int lat;
    int k;
    int h;
    logic [63:0] x;
    logic [63:0] y;
    for (int n = 0; n < 1000; n++) begin
      k = $urandom_range(0, NI - 1);
      x = rnd64();
      y = x;
      for (int r = 0; r < rounds_of(k); r++) y = p_fwd(y);
      send(k, y);
      wait_valid(k, lat);
      h = $urandom_range(0, 2);
      repeat (h) step();
      vec++; if (lat !== rounds_of(k)) begin bad++; $display("FAIL rt_latency n=%0d k=%0d got %0d want %0d", n, k, lat, rounds_of(k)); end
      vec++; if (dout[k] !== x) begin bad++; $display("FAIL rt_data n=%0d k=%0d got %h want %h", n, k, dout[k], x); end
      drain(k);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [63:0] a = rnd64();
    logic [63:0] b = rnd64();
    send(1, a);
    wait_valid(1, lat);
    iv[1] = 1'b1; din[1] = b;
    for (int c = 0; c < 10; c++) begin
      step();
      vec++; if (dout[1] !== model(1, a)) begin bad++; $display("FAIL bp_hold c=%0d got %h want %h", c, dout[1], model(1, a)); end
      vec++; if (ir[1] !== 1'b0) begin bad++; $display("FAIL bp_ir c=%0d got %b want 0", c, ir[1]); end
      vec++; if (ov[1] !== 1'b1) begin bad++; $display("FAIL bp_ov c=%0d got %b want 1", c, ov[1]); end
    end
    ordy[1] = 1'b1; step(); ordy[1] = 1'b0;
    vec++; if (ov[1] !== 1'b0) begin bad++; $display("FAIL bp_release_ov got %b want 0", ov[1]); end
    vec++; if (ir[1] !== 1'b1) begin bad++; $display("FAIL bp_no_accept_in_ready_cycle got %b want 1", ir[1]); end
    step();                    // the held in_valid is accepted here
    iv[1] = 1'b0;
    vec++; if (ir[1] !== 1'b0) begin bad++; $display("FAIL bp_accept got %b want 0", ir[1]); end
    wait_valid(1, lat);
    vec++; if (lat !== 2) begin bad++; $display("FAIL bp_latency got %0d want 2", lat); end
    vec++; if (dout[1] !== model(1, b)) begin bad++; $display("FAIL bp_second got %h want %h", dout[1], model(1, b)); end
    drain(1);
  endtask

  task automatic test_set();
    int lat;
    int seen = 0;
    logic [63:0] d = rnd64();
    // set in RUN together with in_valid
    send(2, rnd64());
    step();
    set_s[2] = 1'b1; iv[2] = 1'b1; din[2] = rnd64();
    step();
    set_s[2] = 1'b0; iv[2] = 1'b0;
    vec++; if (ov[2] !== 1'b0)    begin bad++; $display("FAIL set_run_ov got %b want 0", ov[2]); end
    vec++; if (dout[2] !== 64'd0) begin bad++; $display("FAIL set_run_dout got %h want 0", dout[2]); end
    vec++; if (ir[2] !== 1'b1)    begin bad++; $display("FAIL set_run_idle got %b want 1", ir[2]); end
    for (int c = 0; c < 6; c++) begin step(); if (ov[2]) seen++; end
    vec++; if (seen !== 0) begin bad++; $display("FAIL set_run_discard got %0d valid cycles want 0", seen); end
    send(2, d);
    wait_valid(2, lat);
    vec++; if (dout[2] !== model(2, d)) begin bad++; $display("FAIL set_run_next got %h want %h", dout[2], model(2, d)); end
    drain(2);
    // set in IDLE overrides an accept
    set_s[0] = 1'b1; iv[0] = 1'b1; din[0] = rnd64();
    step();
    set_s[0] = 1'b0; iv[0] = 1'b0;
    vec++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL set_idle_noaccept_ir got %b want 1", ir[0]); end
    vec++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL set_idle_noaccept_ov got %b want 0", ov[0]); end
    // set in DONE together with out_ready
    send(0, d);
    wait_valid(0, lat);
    set_s[0] = 1'b1; ordy[0] = 1'b1;
    step();
    set_s[0] = 1'b0; ordy[0] = 1'b0;
    vec++; if (ov[0] !== 1'b0)    begin bad++; $display("FAIL set_done_ov got %b want 0", ov[0]); end
    vec++; if (dout[0] !== 64'd0) begin bad++; $display("FAIL set_done_dout got %h want 0", dout[0]); end
    vec++; if (st[0] !== 1'b0)    begin bad++; $display("FAIL set_done_status got %b want 0", st[0]); end
  endtask

  initial begin
    for (int j = 0; j < 64; j++) FWD[INV[j]] = j;
    for (int k = 0; k < NI; k++) begin
      set_s[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0; din[k] = '0;
    end
    test_reset();
    test_vectors();
    test_reset_mid_run();
    test_round_trip();
    test_backpressure();
    test_set();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/inverse_permute_map.md
Name: inverse_permute_map

Overview:
- Decrypt-side counterpart of the 64-bit forward bit-permutation stage in the custom encrypter v2 datapath.
- Applies the inverse of the fixed 64-entry forward permutation, iterated ROUNDS times, so that output equals the pre-permutation block.
- Sits between the ciphertext input buffer and the decrypt round logic, with valid/ready handshakes on both sides.

Parameters:
- ROUNDS, 1, number of inverse-permutation passes per block (1..255); must equal the encrypt-side pass count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- set  input  1  synchronous abort/clear, same meaning as the encrypt stage: return to IDLE and zero outputs
- in_valid  input  1  data_in holds a block
- in_ready  output  1  block can be accepted
- data_in  input  [0:63]  permuted block; bit 0 is the MSB
- out_valid  output  1  data_out holds a finished block
- out_ready  input  1  downstream accepts data_out
- data_out  output  [0:63]  recovered block; bit 0 is the MSB
- status  output  1  high while in DONE; mirrors out_valid for legacy status polling

Behaviour:
- Forward map F[i] (encrypt side computes out[i] = in[F[i]]) is fixed.
- This block implements inverse table INV, defined by out[j] = in[INV[j]]. INV[0..63] =
  26,51,41,11,34,56,12,50,61,25,55,44,35,49,21,58,
  24,43,18,2,33,36,52,32,63,1,53,42,57,3,31,22,
  13,54,9,40,5,37,19,62,39,8,29,0,27,20,59,48,
  16,28,45,7,17,4,30,23,47,14,6,38,10,15,46,60
- Reset (rst_n low, asynchronous): state=IDLE, round counter=0, data_out=0, work register=0, out_valid=0, status=0, in_ready=0. in_ready goes to 1 on the first edge after rst_n release.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge, load work = INV(data_in) (round 1 applied at acceptance) and set counter=1.
  - Go to DONE if ROUNDS==1, else to RUN.
- RUN:
  - in_ready=0.
  - Each edge: work = INV(work), counter+1.
  - When counter reaches ROUNDS, go to DONE.
- DONE:
  - data_out=work, out_valid=1, status=1, in_ready=0.
  - Hold data_out stable until out_ready is sampled high, then return to IDLE and drop out_valid.
  - No new block is accepted in the out_ready cycle. Min one IDLE cycle between blocks.
- Latency: out_valid rises ROUNDS edges after acceptance, counting the acceptance edge (ROUNDS=1 means valid in the next cycle).
- Throughput: one block per ROUNDS+1 cycles minimum.
- set high at an edge, in any state: go to IDLE, data_out=0, out_valid=0, status=0, counter=0. Any in-flight block is discarded.
- set overrides a coincident in_valid accept or out_ready.
- Counter is 8 bits. ROUNDS outside 1..255 is a synthesis-time error (generate-time check).
- data_in is ignored outside the IDLE accept cycle.

Optional Feature:
- Macro: PERMUTE_DIR_SEL_EN.
- Defined:
  - Adds input port dir (1 bit), sampled only at the accept edge and stored.
  - dir=1 applies forward map F for all rounds; dir=0 applies INV. One block then serves both encrypt and decrypt paths.
- Undefined: no dir port; INV only.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset mid-RUN (ROUNDS=4, rst_n pulsed low at round 2) -> outputs 0 immediately (asynchronous), in_ready=1 one edge after release.
- ROUNDS=1, data_in=64'h8000_0000_0000_0000 -> next cycle out_valid=1, data_out=64'h0000_0000_0010_0000; data_in=64'h0000_0000_0000_0001 -> 64'h0000_0080_0000_0000.
- ROUNDS=2, data_in=64'h8000_0000_0000_0000 -> out_valid two edges after accept, data_out=64'h0000_4000_0000_0000.
- Round-trip: 1000 random blocks through the forward stage then this block (same ROUNDS) -> output equals original.
- Backpressure: out_ready low for 10 cycles in DONE -> data_out stable, in_ready=0, second in_valid not accepted until one cycle after out_ready.
- set asserted in RUN together with in_valid -> IDLE, out_valid=0, data_out=0, no accept; next block processes correctly.
